// File: rtl/mips_pkg.sv
// Shared register-file constants and writeback source identifiers.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Requester ids, also the encoding of the round-robin last_grant flop
  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; owns the last_grant flop and the grant vector.
module rr_arb2
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  // Grant a lone requester outright; on contention favour whoever lost last time
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == WB_SRC_MEM) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember the winner, only when a transfer actually happens
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= WB_SRC_ALU;
    end else if (|gnt) begin
      last_grant <= gnt[1] ? WB_SRC_MEM : WB_SRC_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: picks one writeback source per cycle,
// stages it in a one-entry output register and flags decode read hazards.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_regWrite
);

  logic [1:0]        gnt;
  logic              transfer;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  logic              reg_write_q;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign transfer   = |gnt;

  // Route the granted request toward the output stage
  always_comb begin
    win_rd   = req0_rd;
    win_data = req0_data;
    if (gnt[1]) begin
      win_rd   = req1_rd;
      win_data = req1_data;
    end
  end

  // Output stage: load on transfer, strobe regWrite for one cycle, never for r0
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q   <= 1'b0;
      rf_rd         <= '0;
      rf_write_data <= '0;
    end else begin
      reg_write_q <= transfer && (win_rd != ADDR_W'(REG_ZERO));
      if (transfer) begin
        rf_rd         <= win_rd;
        rf_write_data <= win_data;
      end
    end
  end

  // Masking with rst keeps a staged write from landing on the reset edge itself
  assign rf_regWrite = reg_write_q & ~rst;

  // A read index is hazardous while any write to it is requested or staged
  always_comb begin
    hazard_rs = (rs != ADDR_W'(REG_ZERO)) &
                ((rf_regWrite & (rf_rd == rs)) |
                 (req0_valid & (req0_rd == rs)) |
                 (req1_valid & (req1_rd == rs)));
    hazard_rt = (rt != ADDR_W'(REG_ZERO)) &
                ((rf_regWrite & (rf_rd == rt)) |
                 (req0_valid & (req0_rd == rt)) |
                 (req1_valid & (req1_rd == rt)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter driving a small behavioural
// 32x32 register file whose A/B read ports follow rs/rt.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [4:0]  rs, rt;
  logic        hazard_rs, hazard_rt;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic        rf_regWrite;

  logic [31:0] regs [32] = '{default: 32'h0};
  logic [31:0] read_a, read_b;

  int checks = 0;
  int errors = 0;
  int gnt0_cnt, gnt1_cnt;
  logic [31:0] d0, d1;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_rd       (req0_rd),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_rd       (req1_rd),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .rs            (rs),
    .rt            (rt),
    .hazard_rs     (hazard_rs),
    .hazard_rt     (hazard_rt),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .rf_regWrite   (rf_regWrite)
  );

  // Behavioural register file: r0 hardwired to zero, write on rising edge
  always @(posedge clk) begin
    if (rf_regWrite && rf_rd != 5'd0) regs[rf_rd] <= rf_write_data;
  end

  assign read_a = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign read_b = (rt == 5'd0) ? 32'h0 : regs[rt];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] r0, input logic [31:0] dat0,
                               input logic v1, input logic [4:0] r1, input logic [31:0] dat1);
    req0_valid = v0; req0_rd = r0; req0_data = dat0;
    req1_valid = v1; req1_rd = r1; req1_data = dat1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rs = 5'd0; rt = 5'd0;
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    step();
    #1;
    checkOutput("rst_ready0", req0_ready, 0);
    checkOutput("rst_ready1", req1_ready, 0);
    step();
    checkOutput("rst_regWrite", rf_regWrite, 0);
    checkOutput("rst_rf_rd", rf_rd, 0);
    checkOutput("rst_rf_data", rf_write_data, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("idle_ready0", req0_ready, 0);
    checkOutput("idle_ready1", req1_ready, 0);
    checkOutput("idle_hz_rs", hazard_rs, 0);
    checkOutput("idle_hz_rt", hazard_rt, 0);

    // Single write from req0
    applyStimulus(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("single_ready0", req0_ready, 1);
    checkOutput("single_ready1", req1_ready, 0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("single_regWrite", rf_regWrite, 1);
    checkOutput("single_rf_rd", rf_rd, 5);
    checkOutput("single_rf_data", rf_write_data, 32'hA5A5A5A5);
    step();
    rs = 5'd5;
    #1;
    checkOutput("single_regWrite_off", rf_regWrite, 0);
    checkOutput("single_readA", read_a, 32'hA5A5A5A5);

    // Contention: req1 wins first, then req0
    applyStimulus(1'b1, 5'd10, 32'h12345678, 1'b1, 5'd11, 32'hDEADBEEF);
    #1;
    checkOutput("cont1_ready1", req1_ready, 1);
    checkOutput("cont1_ready0", req0_ready, 0);
    step();
    checkOutput("cont1_regWrite", rf_regWrite, 1);
    checkOutput("cont1_rf_rd", rf_rd, 11);
    req1_valid = 1'b0;
    #1;
    checkOutput("cont2_ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    checkOutput("cont2_regWrite", rf_regWrite, 1);
    checkOutput("cont2_rf_rd", rf_rd, 10);
    checkOutput("cont2_rf_data", rf_write_data, 32'h12345678);
    step();
    rs = 5'd10; rt = 5'd11;
    #1;
    checkOutput("cont_readA", read_a, 32'h12345678);
    checkOutput("cont_readB", read_b, 32'hDEADBEEF);
    rs = 5'd0; rt = 5'd0;

    // Fairness: continuous contention, last winner was req0 so req1 goes first
    gnt0_cnt = 0; gnt1_cnt = 0;
    d0 = 32'h10000000; d1 = 32'h20000000;
    applyStimulus(1'b1, 5'd20, d0, 1'b1, 5'd21, d1);
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput($sformatf("fair%0d_ready1", i), req1_ready, (i % 2 == 0));
      checkOutput($sformatf("fair%0d_ready0", i), req0_ready, (i % 2 == 1));
      if (req0_ready) gnt0_cnt++;
      if (req1_ready) gnt1_cnt++;
      step();
      checkOutput($sformatf("fair%0d_regWrite", i), rf_regWrite, 1);
      if (i % 2 == 0) begin
        checkOutput($sformatf("fair%0d_data", i), rf_write_data, d1);
        d1 = d1 + 1; req1_data = d1;
      end else begin
        checkOutput($sformatf("fair%0d_data", i), rf_write_data, d0);
        d0 = d0 + 1; req0_data = d0;
      end
    end
    checkOutput("fair_cnt0", gnt0_cnt, 4);
    checkOutput("fair_cnt1", gnt1_cnt, 4);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();

    // Zero register write is accepted but never strobed
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    checkOutput("zero_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    checkOutput("zero_regWrite", rf_regWrite, 0);
    checkOutput("zero_rf_data", rf_write_data, 32'hFFFFFFFF);
    step();
    rs = 5'd0;
    #1;
    checkOutput("zero_readA", read_a, 0);

    // Hazard tracking through request, staging and commit
    rs = 5'd7; rt = 5'd3;
    applyStimulus(1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("hz_req_rs", hazard_rs, 1);
    checkOutput("hz_req_rt", hazard_rt, 0);
    step();
    req0_valid = 1'b0;
    #1;
    checkOutput("hz_stage_rs", hazard_rs, 1);
    step();
    checkOutput("hz_done_rs", hazard_rs, 0);
    checkOutput("hz_done_readA", read_a, 32'h00000077);
    rs = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("hz_zero_rs", hazard_rs, 0);
    req0_valid = 1'b0;
    #1;

    // Reset mid-operation: staged write to r9 discarded, last_grant cleared
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99999999);
    #1;
    checkOutput("mid_ready1", req1_ready, 1);
    step();
    rst = 1'b1;
    applyStimulus(1'b1, 5'd12, 32'h0C0C0C0C, 1'b1, 5'd13, 32'h0D0D0D0D);
    #1;
    checkOutput("mid_rst_regWrite", rf_regWrite, 0);
    checkOutput("mid_rst_ready0", req0_ready, 0);
    checkOutput("mid_rst_ready1", req1_ready, 0);
    step();
    checkOutput("mid_rf_rd", rf_rd, 0);
    checkOutput("mid_rf_data", rf_write_data, 0);
    rst = 1'b0;
    rs = 5'd9;
    #1;
    checkOutput("mid_reg9", read_a, 0);
    checkOutput("mid_lastgrant_ready1", req1_ready, 1);
    checkOutput("mid_lastgrant_ready0", req0_ready, 0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
